// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operation codes, issue-sequencer states and the
// fixed per-operation latency table used by the sequencer and the arithmetic units.
package fpu_pkg;

    typedef enum logic [3:0] {
        FADD   = 4'b1000,
        FSUB   = 4'b1001,
        FDIV   = 4'b1010,
        FSQRT  = 4'b1011,
        FCVTWS = 4'b1100,
        FCVTSW = 4'b1101,
        FMUL   = 4'b1110,
        FUNDEF = 4'b1111
    } fpu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fpu_seq_state_t;

    localparam int LAT_ADDSUB_DEF = 3;
    localparam int LAT_MUL_DEF    = 2;
    localparam int LAT_DIV_DEF    = 8;
    localparam int LAT_SQRT_DEF   = 8;
    localparam int LAT_CVT_DEF    = 2;

    // Codes without a dedicated unit (including 1111) finish after one cycle.
    function automatic logic [5:0] fpu_latency(
        input fpu_op_t op,
        input int      lat_addsub = LAT_ADDSUB_DEF,
        input int      lat_mul    = LAT_MUL_DEF,
        input int      lat_div    = LAT_DIV_DEF,
        input int      lat_sqrt   = LAT_SQRT_DEF,
        input int      lat_cvt    = LAT_CVT_DEF
    );
        case (op)
            FADD, FSUB:     return 6'(lat_addsub);
            FMUL:           return 6'(lat_mul);
            FDIV:           return 6'(lat_div);
            FSQRT:          return 6'(lat_sqrt);
            FCVTWS, FCVTSW: return 6'(lat_cvt);
            default:        return 6'd1;
        endcase
    endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// 5-bit loadable down-counter used to time multi-cycle FPU operations.
// Load has priority over enable; the count holds at zero instead of wrapping.
module fpu_lat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [4:0] load_val_i,
    output logic [4:0] count_o,
    output logic       zero_o
);

    logic [4:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 5'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != 5'd0)) begin
            count_q <= count_q - 5'd1;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == 5'd0);

endmodule

// File: rtl/fpu_issue_seq.sv
// Multi-cycle FPU issue sequencer: starts the unit, stalls the pipeline for the
// op latency and emits one completion pulse. Optional FPU_PERF_CNT_EN adds perf counters.
module fpu_issue_seq
    import fpu_pkg::*;
#(
    parameter int LAT_ADDSUB = LAT_ADDSUB_DEF,
    parameter int LAT_MUL    = LAT_MUL_DEF,
    parameter int LAT_DIV    = LAT_DIV_DEF,
    parameter int LAT_SQRT   = LAT_SQRT_DEF,
    parameter int LAT_CVT    = LAT_CVT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [3:0]  alu_control,
    input  logic        fpu_stall_op,
    input  logic        alu_reg_write,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        stall,
    output logic        unit_start,
    output logic [3:0]  unit_op,
    output logic        done_valid,
    output logic [4:0]  done_rd,
    output logic        done_to_int
`ifdef FPU_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_fpu_ops
`endif
);

    fpu_seq_state_t state_q;
    logic [3:0]     unit_op_q;
    logic [4:0]     done_rd_q;
    logic           done_to_int_q;

    logic [5:0] lat;
    logic [4:0] lat_load;
    logic       accept;
    logic       cnt_load;
    logic       cnt_en;
    logic [4:0] cnt_load_val;
    logic [4:0] cnt_value;
    logic       cnt_zero;

    always_comb begin
        lat      = fpu_latency(fpu_op_t'(alu_control), LAT_ADDSUB, LAT_MUL, LAT_DIV, LAT_SQRT, LAT_CVT);
        lat_load = (lat >= 6'd2) ? 5'(lat - 6'd2) : 5'd0;
    end

    assign accept       = (state_q == IDLE) && issue_valid && fpu_stall_op && !flush;
    assign cnt_load     = accept || flush;
    assign cnt_load_val = flush ? 5'd0 : lat_load;
    assign cnt_en       = (state_q == BUSY);

    fpu_lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (cnt_load_val),
        .count_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

    // A flush in any state abandons the op; the latched tag is left in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            unit_op_q     <= 4'd0;
            done_rd_q     <= 5'd0;
            done_to_int_q <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        unit_op_q     <= alu_control;
                        done_rd_q     <= rd;
                        done_to_int_q <= alu_reg_write;
                        state_q       <= (lat >= 6'd2) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall       = accept || (state_q == BUSY);
    assign unit_start  = accept;
    assign done_valid  = (state_q == DONE) && !flush;
    assign unit_op     = unit_op_q;
    assign done_rd     = done_rd_q;
    assign done_to_int = done_to_int_q;

`ifdef FPU_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_ops_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_ops_q   <= 32'd0;
        end else begin
            if (stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (done_valid) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_fpu_ops      = perf_ops_q;
`endif

    logic unused_cnt;
    assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq; completions are matched against a scoreboard
// of tags and due cycles pushed at issue time. Perf ports follow FPU_PERF_CNT_EN.
module tb_fpu_issue_seq;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [3:0]  alu_control;
    logic        fpu_stall_op;
    logic        alu_reg_write;
    logic [4:0]  rd;
    logic        flush;
    logic        stall;
    logic        unit_start;
    logic [3:0]  unit_op;
    logic        done_valid;
    logic [4:0]  done_rd;
    logic        done_to_int;
`ifdef FPU_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_fpu_ops;
`endif

    typedef struct {
        logic [4:0] rd;
        logic       toInt;
        logic [3:0] op;
        int         doneCyc;
    } sbEntry_t;

    sbEntry_t sb[$];
    sbEntry_t monE;
    int       testsRun = 0;
    int       failCount = 0;
    int       cyc = 0;
    int       lastDoneCyc = -1;

    fpu_issue_seq #(
        .LAT_ADDSUB (3),
        .LAT_MUL    (2),
        .LAT_DIV    (8),
        .LAT_SQRT   (8),
        .LAT_CVT    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .alu_control   (alu_control),
        .fpu_stall_op  (fpu_stall_op),
        .alu_reg_write (alu_reg_write),
        .rd            (rd),
        .flush         (flush),
        .stall         (stall),
        .unit_start    (unit_start),
        .unit_op       (unit_op),
        .done_valid    (done_valid),
        .done_rd       (done_rd),
        .done_to_int   (done_to_int)
`ifdef FPU_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_fpu_ops      (perf_fpu_ops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic int modelLat(input logic [3:0] op);
        case (op)
            4'b1000, 4'b1001: return 3;
            4'b1110:          return 2;
            4'b1010:          return 8;
            4'b1011:          return 8;
            4'b1100, 4'b1101: return 2;
            default:          return 1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every completion must match the oldest outstanding issue, on its due cycle.
    always @(negedge clk) begin
        if (!rst && done_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                monE = sb.pop_front();
                checkOutput("done_rd", 32'(done_rd), 32'(monE.rd));
                checkOutput("done_to_int", 32'(done_to_int), 32'(monE.toInt));
                checkOutput("unit_op", 32'(unit_op), 32'(monE.op));
                checkOutput("done_cycle", 32'(cyc), 32'(monE.doneCyc));
            end
            lastDoneCyc = cyc;
        end
    end

    // Presents one instruction in EX and holds it until the pipeline advances.
    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rdIn, input logic toInt);
        int lat;
        int stallCnt;
        bit seenLow;
        issue_valid   = 1'b1;
        alu_control   = op;
        fpu_stall_op  = op[3];
        rd            = rdIn;
        alu_reg_write = toInt;
        flush         = 1'b0;
        lat = op[3] ? modelLat(op) : 0;
        if (op[3]) sb.push_back('{rdIn, toInt, op, cyc + lat});
        #1;
        checkOutput("unit_start_at_issue", 32'(unit_start), 32'(op[3]));
        checkOutput("stall_at_issue", 32'(stall), 32'(op[3]));
        stallCnt = 0;
        seenLow  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!stall) begin
                seenLow = 1'b1;
                break;
            end
            stallCnt++;
            @(posedge clk);
            #1;
        end
        checkOutput("stall_released", 32'(seenLow), 32'd1);
        checkOutput("stall_cycles", 32'(stallCnt), 32'(lat));
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
        checkOutput({tag, "_unit_start"}, 32'(unit_start), 32'd0);
        checkOutput({tag, "_unit_op"}, 32'(unit_op), 32'd0);
        checkOutput({tag, "_done_valid"}, 32'(done_valid), 32'd0);
        checkOutput({tag, "_done_rd"}, 32'(done_rd), 32'd0);
        checkOutput({tag, "_done_to_int"}, 32'(done_to_int), 32'd0);
`ifdef FPU_PERF_CNT_EN
        checkOutput({tag, "_perf_stall"}, perf_stall_cycles, 32'd0);
        checkOutput({tag, "_perf_ops"}, perf_fpu_ops, 32'd0);
`endif
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        issue_valid   = 1'b0;
        alu_control   = 4'd0;
        fpu_stall_op  = 1'b0;
        alu_reg_write = 1'b0;
        rd            = 5'd0;
        flush         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        nextCycle();

        // FMUL, rd=7
        applyStimulus(4'b1110, 5'd7, 1'b0);

        // FDIV followed directly by FADD
        applyStimulus(4'b1010, 5'd3, 1'b0);
        checkOutput("fadd_after_done_gap", 32'(cyc - lastDoneCyc), 32'd1);
        applyStimulus(4'b1000, 5'd4, 1'b0);

        // FCVTWS writing the integer file; tag must persist afterwards
        applyStimulus(4'b1100, 5'd10, 1'b1);
        nextCycle();
        checkOutput("tag_hold_rd", 32'(done_rd), 32'd10);
        checkOutput("tag_hold_to_int", 32'(done_to_int), 32'd1);
        checkOutput("tag_hold_op", 32'(unit_op), 32'hC);

        // FSQRT flushed in its third BUSY cycle
        issue_valid = 1'b1; alu_control = 4'b1011; fpu_stall_op = 1'b1; rd = 5'd6; alu_reg_write = 1'b0;
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("sqrt_busy_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        issue_valid = 1'b0;
        #1;
        checkOutput("flush_busy_done", 32'(done_valid), 32'd0);
        nextCycle();
        flush = 1'b0;
        #1;
        checkOutput("after_flush_stall", 32'(stall), 32'd0);
        repeat (10) nextCycle();
        applyStimulus(4'b1000, 5'd5, 1'b0);

        // Non-stall op (FEQ) held for five cycles
        for (int i = 0; i < 5; i++) applyStimulus(4'b0010, 5'd11, 1'b1);

        // Flush landing in the DONE cycle suppresses the completion
        issue_valid = 1'b1; alu_control = 4'b1110; fpu_stall_op = 1'b1; rd = 5'd8; alu_reg_write = 1'b0;
        nextCycle();
        nextCycle();
        flush = 1'b1;
        issue_valid = 1'b0;
        #1;
        checkOutput("flush_done_valid", 32'(done_valid), 32'd0);
        checkOutput("flush_done_stall", 32'(stall), 32'd0);
        nextCycle();
        flush = 1'b0;
        #1;
        checkOutput("flush_done_next_stall", 32'(stall), 32'd0);

        // Flush concurrent with an issue: the issue is dropped
        issue_valid = 1'b1; alu_control = 4'b1010; fpu_stall_op = 1'b1; rd = 5'd2; flush = 1'b1;
        #1;
        checkOutput("flush_issue_start", 32'(unit_start), 32'd0);
        checkOutput("flush_issue_stall", 32'(stall), 32'd0);
        nextCycle();
        issue_valid = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("flush_issue_next_stall", 32'(stall), 32'd0);
        repeat (10) nextCycle();

        // Undefined code 1111 has latency 1
        applyStimulus(4'b1111, 5'd9, 1'b1);

        // Asynchronous reset in the middle of an FDIV
        issue_valid = 1'b1; alu_control = 4'b1010; fpu_stall_op = 1'b1; rd = 5'd3; alu_reg_write = 1'b1;
        nextCycle();
        nextCycle();
        nextCycle();
        issue_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        nextCycle();
        rst = 1'b0;
        nextCycle();
        applyStimulus(4'b1001, 5'd12, 1'b1);

        repeat (3) nextCycle();
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
